// File: rtl/ma216_audio_i2s.sv
// MA216 audio output stage: DAC capture, RC low-pass model, mono I2S.
// Single clock domain; audio_in is resynchronized and deglitched here.
module ma216_audio_i2s #(
  parameter int SCLK_DIV     = 4,
  parameter int FILTER_SHIFT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  audio_in,
  input  logic        mute,
  output logic        audio_sclk,
  output logic        audio_lrck,
  output logic        audio_sdata,
  output logic        sample_strobe,
  output logic [15:0] pcm_out
);

  localparam int DW =
    (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE =
    DW'(SCLK_DIV / 2 - 1);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s3;
  logic [7:0] held;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 8'h80;
      s2   <= 8'h80;
      s3   <= 8'h80;
      held <= 8'h80;
    end else begin
      s1 <= audio_in;
      s2 <= s1;
      s3 <= s2;
      if (s2 == s3) begin
        held <= s3;
      end
    end
  end

  logic [15:0]        x;
  logic [15:0]        y;
  logic [15:0]        y_next;
  logic signed [16:0] diff;
  logic signed [16:0] step;

  assign x = {~held[7], held[6:0], 8'h00};

  // Arithmetic shift floors, so rising steps settle just below x.
  always_comb begin
    diff   = {x[15], x} - {y[15], y};
    step   = diff >>> FILTER_SHIFT;
    y_next = 16'({y[15], y} + step);
  end

  logic [DW-1:0] div;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_nxt;
  logic [4:0]    slot_pos;
  logic [3:0]    idx;
  logic          in_slot;
  logic          sdata_nxt;
  logic          fall;
  logic          rise;
  logic          frame_start;
  logic [15:0]   shadow;

  assign fall        = (div == DIV_LAST);
  assign rise        = (div == DIV_PRE);
  assign bit_nxt     = bit_cnt + 6'd1;
  assign frame_start = fall && (bit_cnt == 6'd63);
  assign slot_pos    = bit_nxt[4:0];

  // Position p maps to shadow[16-p]; p=16 wraps to index 0.
  assign idx     = 4'd0 - slot_pos[3:0];
  assign in_slot = (slot_pos != 5'd0) &&
                   (slot_pos <= 5'd16);

  always_comb begin
    sdata_nxt = 1'b0;
    unique case (1'b1)
      in_slot: sdata_nxt = shadow[idx];
      default: sdata_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div           <= '0;
      bit_cnt       <= 6'd63;
      audio_sclk    <= 1'b0;
      audio_lrck    <= 1'b0;
      audio_sdata   <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= frame_start;
      if (fall) begin
        div         <= '0;
        bit_cnt     <= bit_nxt;
        audio_sclk  <= 1'b0;
        audio_lrck  <= bit_nxt[5];
        audio_sdata <= sdata_nxt;
      end else begin
        div <= div + DW'(1);
        if (rise) begin
          audio_sclk <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y      <= '0;
      shadow <= '0;
    end else if (frame_start) begin
      y      <= y_next;
      shadow <= mute ? 16'h0000 : y_next;
    end
  end

  assign pcm_out = y;

endmodule

// File: doc/ma216_audio_i2s.md
# ma216_audio_i2s

Output stage directly downstream of the MA216 sound board. It takes the board's 8-bit unsigned DAC latch value and synchronizes it into the audio clock domain. It then converts the value to signed 16-bit PCM and applies a one-pole low-pass filter that models the analog output RC. The result is serialized as mono-duplicated I2S to the platform audio codec.

## Interface
Parameters:
- SCLK_DIV, 4: clk cycles per SCLK period. Must be even and ≥ 2.
- FILTER_SHIFT, 3: low-pass coefficient 2^-FILTER_SHIFT. 0 = bypass (y = x). Legal range 0..8.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  audio clock, 12.288 MHz nominal.
- reset_n  in  1  asynchronous active-low reset.
- audio_in  in  8  unsigned DAC value from the sound board. Asynchronous to clk; 0x80 = silence.
- mute  in  1  synchronous to clk. When 1, zeros are serialized.
- audio_sclk  out  1  I2S bit clock, clk/SCLK_DIV.
- audio_lrck  out  1  I2S word select: 0 = left, 1 = right.
- audio_sdata  out  1  I2S serial data, MSB first.
- sample_strobe  out  1  one-cycle pulse per frame start.
- pcm_out  out  16  current filtered sample, signed. Not affected by mute.

## Operation
- **Input capture**
  - audio_in passes through three flops s1→s2→s3.
  - `held` loads s3 only on cycles where s2 == s3, so single-cycle glitches are rejected.
  - `held` resets to 0x80.
- **Conversion:** x = {~held[7], held[6:0], 8'h00}.
  - 0x80 → 0x0000, 0xFF → 0x7F00, 0x00 → 0x8000.
- **Filter**, once per frame start:
  - y ← y + ((x − y) >>> FILTER_SHIFT).
  - Difference computed in 17-bit signed; shift is arithmetic (floor); result truncated to 16 bits. No overflow is possible.
  - y resets to 0.
  - Floor semantics are required: a rising step settles up to 2^FILTER_SHIFT − 1 LSB below x; a falling step settles exactly on x.
- **pcm_out** = y, registered.
- **Serializer**
  - Counter div (0..SCLK_DIV−1) and bit index bit (0..63).
  - bit 0..31 = left slot, 32..63 = right slot.
  - Slot position p = bit mod 32. sdata = shadow[16−p] for p = 1..16, else 0. This gives the I2S one-bit delay after the lrck edge.
  - The same shadow word is sent in both slots.
- **Frame start** = the edge that enters bit 0. At that edge:
  - y updates.
  - shadow ← mute ? 0 : y_next.
  - pcm_out ← y_next.
  - sample_strobe ← 1 for exactly one cycle.

## Timing
- **Reset values**
  - Outputs: audio_sclk = 0, audio_lrck = 0, audio_sdata = 0, sample_strobe = 0, pcm_out = 0.
  - Internals: shadow = 0, div = 0, bit = 63, s1..s3 = 0x80.
  - Assertion of reset_n clears everything immediately, mid-frame included.
- **E_fall:** the edge where div wraps SCLK_DIV−1→0.
  - bit increments mod 64; sclk ← 0.
  - lrck ← new bit[5]; sdata ← value for the new bit.
- **E_rise:** the edge where div goes SCLK_DIV/2−1 → SCLK_DIV/2; sclk ← 1.
- Data and lrck change only on SCLK falling edges. The receiver samples on the rising edge, SCLK_DIV/2 clk later.
- **First frame start:** the SCLK_DIV-th rising clk edge after reset_n deasserts. Subsequent frame starts every 64·SCLK_DIV cycles (256; 48 kHz at 12.288 MHz).
- **Input latency:** a stable audio_in change reaches `held` in 4 clk edges. It is used at the next frame start.
- **mute timing:** mute is sampled only at frame start. It takes effect for the whole next frame, never mid-frame.
- **Simultaneous events:** if `held` changes on the frame-start edge itself, the old `held` is used.

## Test plan
1. **Reset and idle.** Hold reset_n low, then release with audio_in = 0x80 → all outputs 0 during reset. sclk period 4 clk; lrck toggles every 128 clk; first sample_strobe at edge 4 after release, then every 256 clk; pcm_out stays 0x0000; sdata stays 0.
2. **Bypass, positive full scale.** FILTER_SHIFT = 0, audio_in = 0xFF → pcm_out = 0x7F00 at the next frame start. Both slots, sampled on sclk rise, show bits 1..16 = 0111_1111_0000_0000; bits 0 and 17..31 = 0.
3. **Filter step response.** FILTER_SHIFT = 3, y = 0, audio_in steps 0x80→0xFF → pcm_out sequence 0x0FE0, 0x1DC4, … Settles in [0x7EF9, 0x7F00] and never exceeds 0x7F00. Step to 0x00 from y = 0 → first sample 0xF000.
4. **Glitch rejection.** audio_in = 0x80 with a single-cycle pulse to 0x00 → `held` and pcm_out unchanged. A 3-cycle pulse is accepted.
5. **Mute.** With audio_in = 0xFF, assert mute mid-frame → current frame completes with data; next frame sdata = 0 in both slots while pcm_out keeps tracking. Deasserting restores data at the following frame start.
6. **Reset mid-frame.** Pull reset_n low at bit 40 → all outputs 0 asynchronously and pcm_out = 0. After release, the frame restarts at bit 0 after 4 clk, with no partial-word output.
